ex_operand_stage: RTL
=====================

// Module: ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and operand-select stage of the 5-stage RV32I core.
//  Captures decoded fields from ID and forwards results from MEM and WB onto rs1/rs2.
//  Selects the ALU A/B operands and drives the ALU combinationally in the EX cycle.
//  Handles stall and flush.
// PARAMETERS
//  XLEN      32  datapath width
//  REG_AW    5   register-address width
// PORTS
//  clk          in   1       core clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  id_valid     in   1       ID presents an instruction
//  id_ready     out  1       stage accepts ID this cycle (= !ex_stall)
//  id_pc        in   XLEN    instruction PC
//  id_rs1_data  in   XLEN    register-file read port 1
//  id_rs2_data  in   XLEN    register-file read port 2
//  id_imm       in   XLEN    sign-extended immediate
//  id_rs1_addr  in   REG_AW  source 1 index
//  id_rs2_addr  in   REG_AW  source 2 index
//  id_rd_addr   in   REG_AW  destination index
//  id_alu_op    in   4       ALU opcode {funct7[5],funct3}, alu_op_t encoding
//  id_a_sel     in   1       0: rs1, 1: PC
//  id_b_sel     in   1       0: rs2, 1: imm
//  id_reg_we    in   1       instruction writes rd
//  flush        in   1       kill the instruction held in EX (branch mispredict)
//  ex_stall     in   1       downstream not ready; hold EX
//  mem_rd_addr  in   REG_AW  EX/MEM destination
//  mem_reg_we   in   1       EX/MEM writes rd
//  mem_result   in   XLEN    EX/MEM ALU result
//  wb_rd_addr   in   REG_AW  MEM/WB destination
//  wb_reg_we    in   1       MEM/WB writes rd
//  wb_result    in   XLEN    MEM/WB writeback value
//  ex_valid     out  1       EX holds a live instruction
//  alu_a        out  XLEN    ALU operand A
//  alu_b        out  XLEN    ALU operand B
//  alu_op       out  4       ALU opcode
//  ex_rd_addr   out  REG_AW  destination to EX/MEM
//  ex_reg_we    out  1       id_reg_we & ex_valid
//  ex_store_data out XLEN    forwarded rs2 (store data)
// BEHAVIOUR
//  - Reset (async on rst_n low): every register 0. ex_valid=0, alu_op=ADD (0000),
//    ex_reg_we=0. All outputs 0 while in reset.
//  - Per-edge priority: reset > flush > stall > load.
//    flush=1: ex_valid<=0 next edge, even when ex_stall=1; data fields don't-care.
//    ex_stall=1: fields hold. rs1/rs2 data regs reload with their forwarded values.
//      This keeps an operand that leaves MEM/WB during the stall.
//    Otherwise: all fields <= id_*, ex_valid <= id_valid.
//  - Latency: 1 cycle from ID accept to ALU operands. alu_* are combinational from regs.
//  - Forwarding is combinational in EX. For each source s with address a_s:
//    if a_s!=0 && mem_reg_we && mem_rd_addr==a_s   -> mem_result (MEM wins);
//    elif a_s!=0 && wb_reg_we && wb_rd_addr==a_s   -> wb_result;
//    else registered data. x0 is never forwarded; it always reads its registered value.
//  - alu_a = a_sel ? pc : fwd_rs1.  alu_b = b_sel ? imm : fwd_rs2.
//    ex_store_data = fwd_rs2, independent of b_sel.
//  - ex_reg_we is forced 0 when ex_valid=0. Bubbles never write.
//  - id_ready is combinational = !ex_stall. It does not depend on id_valid.
// CONFIGURATION
//  EX_FORWARD_EN defined: forwarding as above.
//  EX_FORWARD_EN undefined: fwd_rs* = registered data and mem_*/wb_* inputs are ignored.
//    Stall-time operand reload is then a plain hold. The hazard unit must stall on RAW.
// STRUCTURE
//  pipe_pkg: XLEN, REG_AW, alu_op_t enum (ADD 0000, SUB 1000, SLL 0001, SLT 0010,
//    SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111), a_sel_t, b_sel_t.
//  Sub-module fwd_mux: one instance per source (addr, reg data, mem/wb ports) -> data.
//  Remainder: one always_ff register bank plus output muxes.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> ex_valid=0, alu_a=alu_b=0 immediately, async.
//  2 Load: id rs1=5, rs2=7, a_sel=0, b_sel=0, op=ADD -> next cycle alu_a=5, alu_b=7, ex_valid=1.
//  3 Forward priority: rs1_addr=3, mem_rd=3 (0xAA), wb_rd=3 (0xBB), both we=1
//    -> alu_a=0xAA. mem_reg_we=0 -> alu_a=0xBB.
//  4 x0 guard: rs1_addr=0, mem_rd=0, mem_reg_we=1, mem_result=0x55 -> alu_a = registered 0.
//  5 Stall capture: ex_stall=1 with MEM forwarding 0x10 for rs2. Next cycle mem_reg_we=0
//    -> alu_b stays 0x10. id_ready=0 throughout the stall.
//  6 Flush+stall same cycle: flush=1, ex_stall=1 -> ex_valid=0 and ex_reg_we=0 next cycle.
//  Run 2-6 with and without EX_FORWARD_EN. Without it, 3 -> registered value.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the RV32I pipeline: datapath widths, ALU opcode encoding
// ({funct7[5],funct3}) and the EX operand-select enums.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_t;

  typedef enum logic {
    A_SEL_RS1 = 1'b0,
    A_SEL_PC  = 1'b1
  } a_sel_t;

  typedef enum logic {
    B_SEL_RS2 = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID -> EX handshake and decoded-instruction bus. The ID stage is the master;
// the EX operand stage is the slave and returns id_ready.
interface ex_operand_stage_if;
  import pipe_pkg::*;

  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [REG_AW-1:0] id_rd_addr;
  logic [3:0]        id_alu_op;
  logic              id_a_sel;
  logic              id_b_sel;
  logic              id_reg_we;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op,
           id_a_sel, id_b_sel, id_reg_we,
    input  id_ready
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op,
           id_a_sel, id_b_sel, id_reg_we,
    output id_ready
  );

endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source operand bypass: MEM result beats WB result, x0 never bypassed.
// Bypass is compiled in only when EX_FORWARD_EN is defined.
module ex_operand_stage_fwd_mux
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src_addr,
  input  logic [XLEN-1:0]   reg_data,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic              mem_reg_we,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              wb_reg_we,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   fwd_data
);

`ifdef EX_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  logic src_live_s;
  logic mem_hit_s;
  logic wb_hit_s;

  assign src_live_s = (src_addr != {REG_AW{1'b0}});
  assign mem_hit_s  = FWD_EN && src_live_s && mem_reg_we && (mem_rd_addr == src_addr);
  assign wb_hit_s   = FWD_EN && src_live_s && wb_reg_we && (wb_rd_addr == src_addr);

  // Youngest producer wins: MEM holds a later instruction than WB.
  always_comb begin
    fwd_data = reg_data;
    if (mem_hit_s) begin
      fwd_data = mem_result;
    end else if (wb_hit_s) begin
      fwd_data = wb_result;
    end else begin
      fwd_data = reg_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and ALU operand select for the 5-stage RV32I core.
// Optional operand bypass from MEM/WB is enabled by defining EX_FORWARD_EN.
module ex_operand_stage
  import pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  ex_operand_stage_if.slave    id_bus,
  input  logic                 flush,
  input  logic                 ex_stall,
  input  logic [REG_AW-1:0]    mem_rd_addr,
  input  logic                 mem_reg_we,
  input  logic [XLEN-1:0]      mem_result,
  input  logic [REG_AW-1:0]    wb_rd_addr,
  input  logic                 wb_reg_we,
  input  logic [XLEN-1:0]      wb_result,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  output alu_op_t              alu_op,
  output logic [REG_AW-1:0]    ex_rd_addr,
  output logic                 ex_reg_we,
  output logic [XLEN-1:0]      ex_store_data
);

  logic              valid_r;
  logic [XLEN-1:0]   pc_r;
  logic [XLEN-1:0]   rs1_data_r;
  logic [XLEN-1:0]   rs2_data_r;
  logic [XLEN-1:0]   imm_r;
  logic [REG_AW-1:0] rs1_addr_r;
  logic [REG_AW-1:0] rs2_addr_r;
  logic [REG_AW-1:0] rd_addr_r;
  alu_op_t           alu_op_r;
  a_sel_t            a_sel_r;
  b_sel_t            b_sel_r;
  logic              reg_we_r;

  logic [XLEN-1:0]   fwd_rs1_s;
  logic [XLEN-1:0]   fwd_rs2_s;

  assign id_bus.id_ready = !ex_stall;

  ex_operand_stage_fwd_mux u_fwd_rs1 (
    .src_addr    (rs1_addr_r),
    .reg_data    (rs1_data_r),
    .mem_rd_addr (mem_rd_addr),
    .mem_reg_we  (mem_reg_we),
    .mem_result  (mem_result),
    .wb_rd_addr  (wb_rd_addr),
    .wb_reg_we   (wb_reg_we),
    .wb_result   (wb_result),
    .fwd_data    (fwd_rs1_s)
  );

  ex_operand_stage_fwd_mux u_fwd_rs2 (
    .src_addr    (rs2_addr_r),
    .reg_data    (rs2_data_r),
    .mem_rd_addr (mem_rd_addr),
    .mem_reg_we  (mem_reg_we),
    .mem_result  (mem_result),
    .wb_rd_addr  (wb_rd_addr),
    .wb_reg_we   (wb_reg_we),
    .wb_result   (wb_result),
    .fwd_data    (fwd_rs2_s)
  );

  // ID/EX register bank. During a stall the source operands re-capture their
  // bypassed value so a producer retiring out of MEM/WB is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r    <= 1'b0;
      pc_r       <= {XLEN{1'b0}};
      rs1_data_r <= {XLEN{1'b0}};
      rs2_data_r <= {XLEN{1'b0}};
      imm_r      <= {XLEN{1'b0}};
      rs1_addr_r <= {REG_AW{1'b0}};
      rs2_addr_r <= {REG_AW{1'b0}};
      rd_addr_r  <= {REG_AW{1'b0}};
      alu_op_r   <= ALU_ADD;
      a_sel_r    <= A_SEL_RS1;
      b_sel_r    <= B_SEL_RS2;
      reg_we_r   <= 1'b0;
    end else if (flush) begin
      valid_r    <= 1'b0;
    end else if (ex_stall) begin
      rs1_data_r <= fwd_rs1_s;
      rs2_data_r <= fwd_rs2_s;
    end else begin
      valid_r    <= id_bus.id_valid;
      pc_r       <= id_bus.id_pc;
      rs1_data_r <= id_bus.id_rs1_data;
      rs2_data_r <= id_bus.id_rs2_data;
      imm_r      <= id_bus.id_imm;
      rs1_addr_r <= id_bus.id_rs1_addr;
      rs2_addr_r <= id_bus.id_rs2_addr;
      rd_addr_r  <= id_bus.id_rd_addr;
      alu_op_r   <= alu_op_t'(id_bus.id_alu_op);
      a_sel_r    <= a_sel_t'(id_bus.id_a_sel);
      b_sel_r    <= b_sel_t'(id_bus.id_b_sel);
      reg_we_r   <= id_bus.id_reg_we;
    end
  end

  // ALU operand muxes; store data always takes the bypassed rs2.
  always_comb begin
    alu_a = fwd_rs1_s;
    alu_b = fwd_rs2_s;
    case (a_sel_r)
      A_SEL_PC:  alu_a = pc_r;
      A_SEL_RS1: alu_a = fwd_rs1_s;
      default:   alu_a = fwd_rs1_s;
    endcase
    case (b_sel_r)
      B_SEL_IMM: alu_b = imm_r;
      B_SEL_RS2: alu_b = fwd_rs2_s;
      default:   alu_b = fwd_rs2_s;
    endcase
  end

  assign ex_valid      = valid_r;
  assign alu_op        = alu_op_r;
  assign ex_rd_addr    = rd_addr_r;
  assign ex_reg_we     = reg_we_r & valid_r;
  assign ex_store_data = fwd_rs2_s;

endmodule
